vector_scale: RTL
=================

# vector_scale

Multiplies a signed fixed-point vector by a signed fixed-point scalar, with `TILING` lanes per cycle, arithmetic right shift and saturation. It sits directly upstream of the backprop vector adder. Typical use is scaling a delta vector by the learning rate before the adder accumulates it into the weights. It uses the same valid/ready and sticky-overflow conventions as the adder, so `result` connects straight to the adder's `b` input.

## Interface
- `VECTOR_LEN`, 5: number of elements.
- `VEC_CELL_WIDTH`, 8: signed element width.
- `SCALAR_WIDTH`, 8: signed scalar width.
- `RESULT_CELL_WIDTH`, 8: signed output element width.
- `FRACTION_WIDTH`, 4: product right-shift amount (scalar fraction bits).
- `TILING`, 1: multipliers used per CALC cycle, 1..`VECTOR_LEN`.

- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `vector`  in  `VECTOR_LEN*VEC_CELL_WIDTH`  element i at bits `[i*VEC_CELL_WIDTH +: VEC_CELL_WIDTH]`.
- `vector_valid`  in  1.
- `vector_ready`  out  1.
- `scalar`  in  `SCALAR_WIDTH`.
- `scalar_valid`  in  1.
- `scalar_ready`  out  1.
- `result`  out  `VECTOR_LEN*RESULT_CELL_WIDTH`  same packing as `vector`.
- `result_valid`  out  1.
- `result_ready`  in  1.
- `error`  out  1  sticky saturation flag for the current result.

## Operation
- States: IDLE=0, CALC=1, DONE=2, held in a 2-bit state register. `counter` is wide enough to hold `VECTOR_LEN+TILING`.
- **IDLE**
  - `vector_ready` = `scalar_ready` = 1.
  - Accept only when `vector_valid && scalar_valid` in the same cycle.
  - On accept: latch `vector` and `scalar` into internal registers, clear `counter`, `result` and `error`, go to CALC.
  - If only one valid is high, nothing is consumed and the state stays IDLE. The producer holds its valid high.
- **CALC**
  - Inputs are ignored; all computation uses the latched copies.
  - For each lane j in 0..TILING-1 with `counter+j < VECTOR_LEN`:
    - p = signed(elem[counter+j]) * signed(scalar), full width `VEC_CELL_WIDTH+SCALAR_WIDTH`.
    - q = p >>> `FRACTION_WIDTH` (arithmetic shift; rounds toward −inf, no rounding bias).
    - If q > 2^(R−1)−1, write 2^(R−1)−1 and set `error`. If q < −2^(R−1), write −2^(R−1) and set `error`. Otherwise write q[R−1:0].
  - Lanes with index ≥ `VECTOR_LEN` write nothing and contribute no error.
  - `counter` += `TILING`. When `counter >= VECTOR_LEN-TILING`, go to DONE.
- **DONE**
  - `result_valid` = 1; `result` and `error` are held stable.
  - Exit to IDLE on `result_ready`.
  - `result` and `error` keep their values in IDLE until the next accept.
- `error` is OR-accumulated over the vector and never clears mid-vector.

## Timing
- Reset values: state IDLE, `result` = 0, `error` = 0, `result_valid` = 0, `vector_ready` = `scalar_ready` = 1 from the first cycle after the reset edge.
- `rst` has priority in every state. Reset during CALC or DONE discards the operation; no `result_valid` pulse follows.
- Let C = ceil(`VECTOR_LEN`/`TILING`). If the accept happens at rising edge E, CALC occupies the C cycles after E and `result_valid` is high from edge E+C.
- Minimum turnaround: `result_ready` high at the first DONE cycle, readies high 1 cycle later. Accept-to-accept is therefore C+2 cycles minimum.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- `result_ready` is don't-care outside DONE. `vector_valid` and `scalar_valid` are don't-care outside IDLE.

## Test plan
1. Default parameters. vector = [16,32,−16,0,8] (element 0 first), scalar = 8 (0.5).
   - Expect result = [8,16,−8,0,4] and error = 0.
   - `result_valid` rises exactly 5 edges after the accept edge.
2. vector = [127,−128,1,0,0], scalar = 127.
   - Expect result = [127,−128,7,0,0] (1008 saturates, −1016 saturates, 127>>>4 = 7) and error = 1.
   - Error stays 1 until the next accept.
3. vector = [−1,−17,17,0,0], scalar = 16 (1.0).
   - Expect result = [−1,−17,17,0,0] and error = 0.
   - With scalar = 1: expect [−1,−2,1,0,0], confirming floor truncation.
4. Backpressure and single-valid hold:
   - `result_ready` held low 10 cycles in DONE: `result` stable, both readies 0.
   - `vector_valid` high with `scalar_valid` low for 3 cycles: state stays IDLE.
   - Accept occurs only when `scalar_valid` rises.
5. `TILING`=2, `VECTOR_LEN`=5, same stimulus as test 1.
   - Exactly 3 CALC cycles, identical result.
   - Phantom lane 5 does not affect `error`.
6. Assert `rst` in the second CALC cycle.
   - Next cycle: readies = 1, `result_valid` = 0, `result` = 0, `error` = 0.
   - Then test 1 completes normally.

Source files
------------

// File: rtl/vector_scale.sv
// -----------------------------------------------------------------------------
// vector_scale
//
// Multiplies a latched signed fixed-point vector by a latched signed
// fixed-point scalar, TILING lanes per cycle. Each product is arithmetically
// shifted right by FRACTION_WIDTH (floor, no rounding bias) and saturated to
// RESULT_CELL_WIDTH. Any saturated lane sets the sticky error flag for the
// current result. The output side presents the same valid/ready and sticky
// error behaviour as the downstream vector adder, so result feeds its b input.
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset
//   vector        VECTOR_LEN packed signed elements, element i at
//                 [i*VEC_CELL_WIDTH +: VEC_CELL_WIDTH]
//   vector_valid  vector operand offered
//   vector_ready  high in IDLE; operand consumed only together with scalar
//   scalar        signed scalar, FRACTION_WIDTH fraction bits
//   scalar_valid  scalar operand offered
//   scalar_ready  high in IDLE
//   result        VECTOR_LEN packed signed elements, same packing as vector
//   result_valid  high in DONE
//   result_ready  consumer accepts result (only meaningful in DONE)
//   error         sticky saturation flag for the current result
// -----------------------------------------------------------------------------
module vector_scale #(
  parameter int VECTOR_LEN        = 5,
  parameter int VEC_CELL_WIDTH    = 8,
  parameter int SCALAR_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 8,
  parameter int FRACTION_WIDTH    = 4,
  parameter int TILING            = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [VECTOR_LEN*VEC_CELL_WIDTH-1:0]  vector,
  input  logic                                  vector_valid,
  output logic                                  vector_ready,
  input  logic [SCALAR_WIDTH-1:0]               scalar,
  input  logic                                  scalar_valid,
  output logic                                  scalar_ready,
  output logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result,
  output logic                                  result_valid,
  input  logic                                  result_ready,
  output logic                                  error
);

  localparam int PROD_W = VEC_CELL_WIDTH + SCALAR_WIDTH;
  // One extra bit above the wider of product and result keeps the range
  // comparison exact even if RESULT_CELL_WIDTH >= PROD_W.
  localparam int EXT_W  = ((PROD_W > RESULT_CELL_WIDTH) ? PROD_W : RESULT_CELL_WIDTH) + 1;
  localparam int CNT_W  = $clog2(VECTOR_LEN + TILING + 1);
  localparam int VEC_W  = VECTOR_LEN * VEC_CELL_WIDTH;
  localparam int RES_W  = VECTOR_LEN * RESULT_CELL_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                        state_q,  state_d;
  logic [CNT_W-1:0]              counter_q, counter_d;
  logic [VEC_W-1:0]              vec_q,    vec_d;
  logic [SCALAR_WIDTH-1:0]       scalar_q, scalar_d;
  logic [RES_W-1:0]              result_q, result_d;
  logic                          error_q,  error_d;

  int                            lane_idx;
  logic [RESULT_CELL_WIDTH:0]    lane_res;

  // Product, floor shift and saturation for one lane.
  // Returns {overflow, saturated value}.
  function automatic logic [RESULT_CELL_WIDTH:0] scale_sat(
    input logic signed [VEC_CELL_WIDTH-1:0] elem,
    input logic signed [SCALAR_WIDTH-1:0]   scl
  );
    logic signed [PROD_W-1:0] ax;
    logic signed [PROD_W-1:0] sx;
    logic signed [PROD_W-1:0] prod;
    logic signed [EXT_W-1:0]  shifted;
    logic signed [EXT_W-1:0]  max_v;
    logic signed [EXT_W-1:0]  min_v;
    logic signed [RESULT_CELL_WIDTH-1:0] max_r;
    logic signed [RESULT_CELL_WIDTH-1:0] min_r;
    ax      = PROD_W'(elem);
    sx      = PROD_W'(scl);
    prod    = ax * sx;
    shifted = EXT_W'(prod >>> FRACTION_WIDTH);
    max_v   = {{(EXT_W-RESULT_CELL_WIDTH+1){1'b0}}, {(RESULT_CELL_WIDTH-1){1'b1}}};
    min_v   = -max_v - EXT_W'(1);
    max_r   = {1'b0, {(RESULT_CELL_WIDTH-1){1'b1}}};
    min_r   = {1'b1, {(RESULT_CELL_WIDTH-1){1'b0}}};
    if (shifted > max_v) begin
      scale_sat = {1'b1, max_r};
    end else if (shifted < min_v) begin
      scale_sat = {1'b1, min_r};
    end else begin
      scale_sat = {1'b0, shifted[RESULT_CELL_WIDTH-1:0]};
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    vec_d     = vec_q;
    scalar_d  = scalar_q;
    result_d  = result_q;
    error_d   = error_q;
    lane_idx  = 0;
    lane_res  = '0;

    case (state_q)
      IDLE: begin
        // Both operands must arrive together; a lone valid is left pending.
        if (vector_valid && scalar_valid) begin
          vec_d     = vector;
          scalar_d  = scalar;
          counter_d = '0;
          result_d  = '0;
          error_d   = 1'b0;
          state_d   = CALC;
        end
      end

      CALC: begin
        for (int j = 0; j < TILING; j++) begin
          lane_idx = int'(counter_q) + j;
          // Lanes past the end of the vector are phantom: no write, no error.
          if (lane_idx < VECTOR_LEN) begin
            lane_res = scale_sat(vec_q[lane_idx*VEC_CELL_WIDTH +: VEC_CELL_WIDTH],
                                 scalar_q);
            result_d[lane_idx*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] =
              lane_res[RESULT_CELL_WIDTH-1:0];
            if (lane_res[RESULT_CELL_WIDTH]) begin
              error_d = 1'b1;
            end
          end
        end
        counter_d = counter_q + CNT_W'(TILING);
        // Decided on the pre-increment count: this cycle covers the last lanes.
        if (int'(counter_q) >= VECTOR_LEN - TILING) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      counter_q <= '0;
      result_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      result_q  <= result_d;
      error_q   <= error_d;
    end
  end

  // Operand holding registers
  always_ff @(posedge clk) begin
    vec_q    <= vec_d;
    scalar_q <= scalar_d;
  end

  assign vector_ready = (state_q == IDLE);
  assign scalar_ready = (state_q == IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;
  assign error        = error_q;

endmodule
